// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared types and defaults for the pedestrian button front end
//
// Holds the per-button debounce state encoding and the default synchroniser
// depth / debounce length used by ped_button_conditioner and ped_btn_debounce.

package ped_pkg;

  // Debounce FSM states. The encoding is fixed so that state dumps read the
  // same across the controller codebase.
  typedef enum logic [1:0] {
    RELEASED    = 2'b00,
    PRESS_CHK   = 2'b01,
    HELD        = 2'b10,
    RELEASE_CHK = 2'b11
  } deb_state_t;

  // Two flops is the minimum for metastability settling on the raw buttons.
  localparam int DEF_SYNC_STAGES     = 2;

  // Number of consecutive stable samples before a level change is accepted.
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  // True for the states in which the button is considered pressed.
  function automatic logic is_pressed_state(input deb_state_t s);
    return (s == HELD) || (s == RELEASE_CHK);
  endfunction

endpackage : ped_pkg

// File: rtl/ped_button_conditioner_if.sv
// rtl/ped_button_conditioner_if.sv - button/request bundle between buttons, controller and conditioner
//
// Signals:
//   nb_raw, sb_raw  raw asynchronous walk buttons, 1 = pressed
//   serve           controller walk phase active (PG steady or flashing)
//   nb_press        one-cycle pulse on a confirmed north press
//   sb_press        one-cycle pulse on a confirmed south press
//   nb_req, sb_req  latched walk requests, cleared while serve is high
//   req_pending     nb_req | sb_req
//
// Modports:
//   master  the environment side (buttons + controller): drives raw/serve
//   slave   the conditioner: drives press pulses and requests

interface ped_button_conditioner_if;

  logic nb_raw;
  logic sb_raw;
  logic serve;
  logic nb_press;
  logic sb_press;
  logic nb_req;
  logic sb_req;
  logic req_pending;

  modport master (
    output nb_raw,
    output sb_raw,
    output serve,
    input  nb_press,
    input  sb_press,
    input  nb_req,
    input  sb_req,
    input  req_pending
  );

  modport slave (
    input  nb_raw,
    input  sb_raw,
    input  serve,
    output nb_press,
    output sb_press,
    output nb_req,
    output sb_req,
    output req_pending
  );

endinterface : ped_button_conditioner_if

// File: rtl/ped_btn_debounce.sv
// rtl/ped_btn_debounce.sv - synchroniser, debounce FSM and rise pulse for one button
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   raw    asynchronous button input, 1 = pressed
//   rise   combinational: high in the cycle whose edge enters HELD
//   press  registered copy of rise: one-cycle pulse after HELD entry
//   held   registered debounced level (HELD or RELEASE_CHK)

module ped_btn_debounce
  import ped_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise,
  output logic press,
  output logic held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Counter value on the last sample of a check window; reaching it with the
  // input still stable completes the transition.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  // With a single-cycle debounce the CHK states are bypassed entirely.
  localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM: state register
  // ---------------------------------------------------------------------------
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= CNT_ZERO;
      press   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press   <= rise_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: next-state logic
  // ---------------------------------------------------------------------------
  // The counter only runs inside a CHK state and is cleared whenever the FSM
  // settles, so it is bounded by CNT_LAST and cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (sync) begin
          if (DIRECT) begin
            state_d = HELD;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = PRESS_CHK;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_CHK: begin
        if (!sync) begin
          state_d = RELEASED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync) begin
          if (DIRECT) begin
            state_d = RELEASED;
            cnt_d   = CNT_ZERO;
          end else begin
            state_d = RELEASE_CHK;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RELEASE_CHK: begin
        if (sync) begin
          state_d = HELD;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM: output logic
  // ---------------------------------------------------------------------------
  // The rise event is decoded from the current state so that it coincides with
  // the edge that moves the FSM into HELD; the request latch in the top uses it
  // directly so req and press appear after the same edge.
  always_comb begin
    rise_c = 1'b0;
    if (sync) begin
      if (state_q == PRESS_CHK && cnt_q == CNT_LAST) begin
        rise_c = 1'b1;
      end else if (DIRECT && state_q == RELEASED) begin
        rise_c = 1'b1;
      end
    end
  end

  assign rise = rise_c;
  assign held = is_pressed_state(state_q);

endmodule : ped_btn_debounce

// File: rtl/ped_button_conditioner.sv
// rtl/ped_button_conditioner.sv - debounced walk buttons and latched walk requests for the crossing controller
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    ped_button_conditioner_if.slave
//            in : nb_raw, sb_raw, serve
//            out: nb_press, sb_press, nb_req, sb_req, req_pending
//
// Each button passes through its own ped_btn_debounce instance. The requests
// latch on the confirmed rise and hold until the controller enters its walk
// phase (serve), so a short press made during a vehicle phase is never lost.

module ped_button_conditioner
  import ped_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  ped_button_conditioner_if.slave   bus
);

  logic nb_rise, sb_rise;
  logic nb_press_q, sb_press_q;
  logic nb_held, sb_held;
  logic nb_req_q, sb_req_q;

  // ---------------------------------------------------------------------------
  // Per-button conditioning
  // ---------------------------------------------------------------------------
  ped_btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_nb_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.nb_raw),
    .rise  (nb_rise),
    .press (nb_press_q),
    .held  (nb_held)
  );

  ped_btn_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sb_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   (bus.sb_raw),
    .rise  (sb_rise),
    .press (sb_press_q),
    .held  (sb_held)
  );

  // The debounced levels are not needed here; they exist for debug probing.
  logic unused_held;
  assign unused_held = nb_held ^ sb_held;

  // ---------------------------------------------------------------------------
  // Request latches
  // ---------------------------------------------------------------------------
  // serve wins over a same-cycle press: a press confirmed while the crossing is
  // already being served has been satisfied and must not re-arm the request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nb_req_q <= 1'b0;
    end else if (bus.serve) begin
      nb_req_q <= 1'b0;
    end else if (nb_rise) begin
      nb_req_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_req_q <= 1'b0;
    end else if (bus.serve) begin
      sb_req_q <= 1'b0;
    end else if (sb_rise) begin
      sb_req_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.nb_press    = nb_press_q;
  assign bus.sb_press    = sb_press_q;
  assign bus.nb_req      = nb_req_q;
  assign bus.sb_req      = sb_req_q;
  assign bus.req_pending = nb_req_q | sb_req_q;

endmodule : ped_button_conditioner

// File: doc/ped_button_conditioner.md
Name: ped_button_conditioner

Overview:
Front-end stage directly upstream of the pedestrian crossing controller.
- Synchronises and debounces the raw north/south walk buttons (nb_raw, sb_raw).
- Converts each confirmed press into a one-cycle pulse and a latched walk request.
- The latched requests drive the controller's NB/SB inputs and hold until the controller reports that the crossing is being served, so short or bouncy presses are never lost.

Parameters:
- SYNC_STAGES, 2, flip-flops in each input synchroniser; minimum 2.
- DEBOUNCE_CYCLES, 4, consecutive stable clk cycles before a level change is accepted; minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- nb_raw  in  1  north button, asynchronous, 1 = pressed.
- sb_raw  in  1  south button, asynchronous, 1 = pressed.
- serve  in  1  from controller; 1 while the pedestrian walk phase (PG steady or flashing) is active.
- nb_press  out  1  one-cycle pulse on confirmed north press.
- sb_press  out  1  one-cycle pulse on confirmed south press.
- nb_req  out  1  latched north request; wired to controller NB.
- sb_req  out  1  latched south request; wired to controller SB.
- req_pending  out  1  nb_req | sb_req.

Behaviour:
- Reset (async assert, sync to clk on release):
  - synchroniser flops, debounced levels, counters, press and req registers all 0.
  - All outputs 0 while reset is high.
- Synchroniser: per button, a chain of SYNC_STAGES flops; sync output = last stage.
- Debounce: one FSM per button, with states RELEASED, PRESS_CHK, HELD, RELEASE_CHK.
  - RELEASED: if sync=1, load counter to 1 and go to PRESS_CHK; else stay.
  - PRESS_CHK: if sync=0, return to RELEASED (counter cleared). If sync=1 and counter==DEBOUNCE_CYCLES-1, go to HELD and assert the rise event. Otherwise increment the counter.
  - HELD: if sync=0, load counter to 1 and go to RELEASE_CHK.
  - RELEASE_CHK: if sync=1, return to HELD. If sync=0 and counter==DEBOUNCE_CYCLES-1, go to RELEASED. Otherwise increment the counter.
  - DEBOUNCE_CYCLES=1: RELEASED goes straight to HELD (and HELD to RELEASED) on the first stable sample; the CHK states are unused.
  - The counter never exceeds DEBOUNCE_CYCLES and never wraps.
- Latency:
  - Raw high sampled at edge k gives press=1 and req=1 after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - Defaults: raw set before edge 0 gives outputs high after edge 5.
- Press pulse:
  - Registered, high for exactly one cycle per HELD entry.
  - Holding the button produces no further pulses; a release must complete before a new press is recognised.
- Request latch (per channel, registered):
  - If serve=1, req is cleared to 0. Clear has priority over a press in the same cycle, and presses while serve=1 are discarded.
  - Else if the press event occurs, req is set to 1.
  - Else req holds its value.
- Press pulses are still generated while serve=1 (for monitoring); only the latch ignores them.
- Channels are fully independent:
  - simultaneous presses give both pulses in the same cycle and both reqs set;
  - req_pending is combinational OR of the registered reqs.
- Glitch shorter than DEBOUNCE_CYCLES after synchronisation: no pulse, no req, FSM back in RELEASED.
- Reset asserted mid-debounce or with req=1: everything clears.
  - A button still held after reset release needs the full latency before it is recognised.

Decomposition:
- Shared package ped_pkg holds:
  - debounce state typedef (RELEASED=2'b00, PRESS_CHK=2'b01, HELD=2'b10, RELEASE_CHK=2'b11);
  - default SYNC_STAGES and DEBOUNCE_CYCLES constants.
- One sub-module, ped_btn_debounce, contains the synchroniser, debounce FSM/counter and rise pulse. It is instantiated twice; the top adds the request latches and req_pending.

Test Plan:
- Reset: hold reset with nb_raw=sb_raw=1 for 3 cycles, then release. All outputs stay 0 during reset; nb_press and sb_press pulse after edge 5 post-release; nb_req=sb_req=1.
- Clean press: nb_raw 0→1 before edge 0, held 10 cycles, serve=0. nb_press=1 only in the cycle after edge 5; nb_req=1 from edge 5 onward; sb outputs stay 0.
- Bounce: sb_raw toggles 1,0,1,0 each cycle, then holds 1. No pulse during the toggling; a single sb_press 5 edges after the final stable rise.
- Serve clear: nb_req=1, then serve=1 for 1 cycle. nb_req=0 after that edge. A press confirmed while serve=1 gives nb_press but nb_req stays 0.
- Simultaneous: nb_raw and sb_raw rise on the same edge. Both press pulses in the same cycle; req_pending=1.
- Long hold, release and re-press: hold 20 cycles, release 6, press again. Exactly two nb_press pulses; a release of only 2 cycles gives one pulse total.
